// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester identifiers, default bus widths and the grant-selection rule.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Winner among pending requesters; under contention the side that did not
  // win last time goes next, so neither side can starve the other.
  function automatic req_id_e pick_winner(input logic if_req, input logic d_req,
                                          input req_id_e last_grant);
    if (if_req && d_req) begin
      return (last_grant == REQ_D) ? REQ_IF : REQ_D;
    end else if (d_req) begin
      return REQ_D;
    end else begin
      return REQ_IF;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around the memory port arbiter.
// The slave modport is the arbiter's view; master is the core+memory side.
//
// Handshake rules:
//   requester side : a requester raises *_req with stable address/data and
//                    holds them until its one-cycle *_ack; *_rdata is valid
//                    in the ack cycle. Dropping *_req before a grant cancels
//                    the request; dropping it after the grant does not.
//   memory side    : mem_req/mem_we/mem_addr/mem_wdata stay constant while
//                    mem_req is high; the transfer completes in the cycle
//                    where mem_req and mem_ready are both high. mem_ready
//                    with mem_req low is ignored.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;
  logic              err;
  mem_arb_pkg::arb_state_e state_dbg;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, err, state_dbg
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, err, state_dbg
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for a pending memory access. Only present when
// MEM_TIMEOUT_EN is defined. expired is high in the cycle whose wait brings
// the count up to LIMIT, so the owner gives up after exactly LIMIT waits.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count waiting cycles, saturating at LIMIT; clear while no access is open.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// load/store path. Each access runs IDLE -> GRANT_x -> RESP -> IDLE with all
// memory-side and ack outputs registered.
// Optional build macro: MEM_TIMEOUT_EN adds a wait-cycle limit of
// TIMEOUT_CYCLES after which the access is abandoned with err and zero data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state;
  req_id_e           last_grant;
  req_id_e           winner;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              in_grant;

  assign winner   = pick_winner(bus.if_req, bus.d_req, last_grant);
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);

`ifdef MEM_TIMEOUT_EN
  logic tmo_expired;
  logic err_q;

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_grant),
    .enable  (in_grant && mem_req_q && !bus.mem_ready),
    .expired (tmo_expired)
  );

  assign bus.err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus.err        = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, hold memory outputs until mem_ready,
  // then one RESP cycle carrying the requester's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= REQ_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            last_grant <= winner;
            mem_req_q  <= 1'b1;
            if (winner == REQ_D) begin
              state       <= GRANT_D;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              state      <= GRANT_I;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.if_addr;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_req_q && bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= RESP;
            if (state == GRANT_I) begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
              d_ack_q <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_expired) begin
            mem_req_q <= 1'b0;
            state     <= RESP;
            err_q     <= 1'b1;
            if (state == GRANT_I) begin
              if_rdata_q <= '0;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= '0;
              d_ack_q <= 1'b1;
            end
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps from reset, then a randomized
// phase where the bench plays both requesters and the memory and predicts
// every output from the arbitration and latency rules.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  // Leaves rst low for the current cycle so the caller can drive requests.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_mem_req",  bus.mem_req,  0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_ack",   bus.if_ack,   0);
    check("rst_d_ack",    bus.d_ack,    0);
    check("rst_busy",     bus.busy,     0);
    check("rst_err",      bus.err,      0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata,  0);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / reference model state ----------------
  logic [31:0] exp_q[$];          // expected read data, in completion order
  logic [31:0] mem_model [64];
  bit          if_pend, d_pend;
  logic [31:0] if_a, d_a, d_wd;
  bit          d_w;
  bit          m_req_on, m_win, m_last, m_we, m_ack_side, rdy;
  int          m_ack_cyc, m_free_cyc, waited;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, rd_exp;
  bit          order [4];

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---- fetch only ----
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check("f_mem_req", bus.mem_req, 1);
    check("f_mem_addr", bus.mem_addr, 32'h100);
    check("f_mem_we", bus.mem_we, 0);
    check("f_busy", bus.busy, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
    tick();
    check("f_if_ack", bus.if_ack, 1);
    check("f_if_rdata", bus.if_rdata, 32'h00500093);
    check("f_d_ack", bus.d_ack, 0);
    check("f_mem_req_off", bus.mem_req, 0);
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.if_req = 1'b0;
    tick();
    check("f_if_ack_pulse", bus.if_ack, 0);
    check("f_d_ack_idle", bus.d_ack, 0);
    check("f_busy_idle", bus.busy, 0);

    // ---- load 0x12345678 ----
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    tick();
    check("l_mem_addr", bus.mem_addr, 32'h80);
    check("l_mem_we", bus.mem_we, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    tick();
    check("l_d_ack", bus.d_ack, 1);
    check("l_d_rdata", bus.d_rdata, 32'h12345678);
    check("l_if_ack", bus.if_ack, 0);
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    tick();
    check("l_d_ack_pulse", bus.d_ack, 0);

    // ---- store with three wait cycles ----
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s_mem_req", bus.mem_req, 1);
      check("s_mem_we", bus.mem_we, 1);
      check("s_mem_addr", bus.mem_addr, 32'h40);
      check("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      check("s_d_ack_wait", bus.d_ack, 0);
      if (i == 3) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
      end
    end
    tick();
    check("s_d_ack", bus.d_ack, 1);
    check("s_d_rdata_kept", bus.d_rdata, 32'h12345678);
    bus.mem_ready = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick();
    check("s_d_ack_pulse", bus.d_ack, 0);
    check("s_busy_idle", bus.busy, 0);

    // ---- load returning zero ----
    bus.d_req = 1'b1; bus.d_addr = 32'h84;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0;
    tick();
    check("z_d_ack", bus.d_ack, 1);
    check("z_d_rdata", bus.d_rdata, 0);
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    tick();

    // ---- reset in the middle of a load ----
    bus.d_req = 1'b1; bus.d_addr = 32'h88;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    tick();
    check("r_pre_d_rdata", bus.d_rdata, 32'h55AA55AA);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    check("r_grant", bus.mem_req, 1);
    rst = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
    tick();
    check("r_mem_req", bus.mem_req, 0);
    check("r_busy", bus.busy, 0);
    check("r_d_ack", bus.d_ack, 0);
    check("r_d_rdata", bus.d_rdata, 0);
    rst = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    tick();
    check("r_no_late_ack", bus.d_ack, 0);

    // ---- contention from reset: D, IF, D, IF ----
    do_reset();
    order = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req  = 1'b1; bus.d_addr  = 32'h300; bus.d_we = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("c_mem_req", bus.mem_req, 1);
      check("c_mem_addr", bus.mem_addr, order[t] ? 32'h300 : 32'h200);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1000 + t;
      tick();
      check("c_d_ack", bus.d_ack, order[t]);
      check("c_if_ack", bus.if_ack, !order[t]);
      bus.mem_ready = 1'b0;
      tick();
      check("c_ack_pulse", bus.if_ack | bus.d_ack, 0);
      check("c_busy_idle", bus.busy, 0);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // ---- memory never answers: give up after four waits ----
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE;
    tick();
    check("t_pre_if_rdata", bus.if_rdata, 32'hCAFE);
    bus.mem_ready = 1'b0; bus.if_req = 1'b0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t_mem_req_wait", bus.mem_req, 1);
      check("t_err_wait", bus.err, 0);
    end
    tick();
    check("t_if_ack", bus.if_ack, 1);
    check("t_err", bus.err, 1);
    check("t_if_rdata", bus.if_rdata, 0);
    check("t_mem_req_off", bus.mem_req, 0);
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    tick();
    check("t_err_pulse", bus.err, 0);
    check("t_busy_idle", bus.busy, 0);
    tick();
    check("t_next_grant", bus.mem_req, 1);
    check("t_next_addr", bus.mem_addr, 32'h20);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
    tick();
    check("t_next_ack", bus.d_ack, 1);
    check("t_next_err", bus.err, 0);
    check("t_next_rdata", bus.d_rdata, 32'h99);
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    tick();
`endif

    // ---- randomized phase against the reference model ----
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
    do_reset();
    if_pend = 0; d_pend = 0; if_a = '0; d_a = '0; d_wd = '0; d_w = 0;
    m_req_on = 0; m_last = 0; m_win = 0; m_we = 0; m_ack_side = 0;
    m_ack_cyc = -1; m_free_cyc = 0; waited = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // compare the current cycle against the model
      check("x_mem_req", bus.mem_req, m_req_on);
      if (m_req_on) begin
        check("x_mem_addr", bus.mem_addr, m_addr);
        check("x_mem_we", bus.mem_we, m_we);
        if (m_we) check("x_mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("x_if_ack", bus.if_ack, (cyc == m_ack_cyc) && !m_ack_side);
      check("x_d_ack", bus.d_ack, (cyc == m_ack_cyc) && m_ack_side);
      check("x_busy", bus.busy, cyc < m_free_cyc);
      check("x_err", bus.err, 0);
      check("x_if_rdata", bus.if_rdata, m_if_rdata);
      check("x_d_rdata", bus.d_rdata, m_d_rdata);
      if (cyc == m_ack_cyc && exp_q.size() > 0) begin
        rd_exp = exp_q.pop_front();
        check("x_ack_data", m_ack_side ? bus.d_rdata : bus.if_rdata,
              (m_ack_side && m_we) ? m_d_rdata : rd_exp);
      end

      // requesters
      if (cyc == m_ack_cyc) begin
        if (m_ack_side) d_pend = 0; else if_pend = 0;
      end
      if (if_pend && $urandom_range(15) == 0) if_pend = 0;
      else if (!if_pend && !(cyc < m_free_cyc && !m_win) && $urandom_range(2) == 0) begin
        if_pend = 1; if_a = 32'($urandom_range(63)) * 4;
      end
      if (d_pend && $urandom_range(15) == 0) d_pend = 0;
      else if (!d_pend && !(cyc < m_free_cyc && m_win) && $urandom_range(2) == 0) begin
        d_pend = 1; d_a = 32'($urandom_range(63)) * 4; d_w = 1'($urandom_range(1)); d_wd = $urandom;
      end
      bus.if_req = if_pend; bus.if_addr = if_a;
      bus.d_req = d_pend; bus.d_addr = d_a; bus.d_we = d_w; bus.d_wdata = d_wd;

      // memory: answer within three request cycles, with stray readies when idle
      if (m_req_on) rdy = (waited == 2) || ($urandom_range(2) == 0);
      else rdy = ($urandom_range(3) == 0);
      bus.mem_ready = rdy;
      bus.mem_rdata = (rdy && m_req_on) ? mem_model[bus.mem_addr[7:2]] : $urandom;

      // model advances across the coming edge
      if (m_req_on) begin
        if (rdy) begin
          rd_exp = mem_model[m_addr[7:2]];
          exp_q.push_back(rd_exp);
          if (m_win) begin
            if (!m_we) m_d_rdata = rd_exp;
            else mem_model[m_addr[7:2]] = m_wdata;
          end else begin
            m_if_rdata = rd_exp;
          end
          m_req_on = 0; m_ack_side = m_win;
          m_ack_cyc = cyc + 1; m_free_cyc = cyc + 2;
        end else begin
          waited++;
        end
      end else if (cyc >= m_free_cyc && (if_pend || d_pend)) begin
        if (if_pend && d_pend) m_win = !m_last;
        else m_win = d_pend;
        m_last = m_win; m_req_on = 1; waited = 0;
        m_free_cyc = 1 << 30;
        m_addr = m_win ? d_a : if_a;
        m_we = m_win ? d_w : 1'b0;
        m_wdata = d_wd;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
